// File: rtl/vcdl_delay_scan.sv
// VCDL tap-delay calibration: sweeps taps 0..31, majority-votes the synchronized
// feedback per tap and loads the first low->high tap (or DEFAULT_DELAY).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RST    | cycle following a reset edge; outputs at reset values
// ST_INIT   | load DEFAULT_DELAY into the delay line
// ST_IDLE   | wait for start_i / manual_ld_i
// ST_MLOAD  | load captured manual tap
// ST_LOAD   | load current scan tap
// ST_SETTLE | let the delay line and synchronizer settle
// ST_SAMPLE | count synchronized feedback ones
// ST_EVAL   | majority vote, edge detect, advance tap
// ST_APPLY  | load found edge tap or DEFAULT_DELAY
// ST_DONE   | one-cycle completion pulse
module vcdl_delay_scan #(
  parameter int         SETTLE_CYCLES = 16,
  parameter int         SAMPLE_LOG2   = 8,
  parameter logic [4:0] DEFAULT_DELAY = 5'd0
) (
  input  logic       delay_clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       manual_ld_i,
  input  logic [4:0] manual_delay_i,
  input  logic       fb_q_i,
  output logic [4:0] delay_o,
  output logic       delay_ld_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       edge_found_o,
  output logic [4:0] edge_tap_o
);

  localparam logic [3:0] ST_RST    = 4'd0;
  localparam logic [3:0] ST_INIT   = 4'd1;
  localparam logic [3:0] ST_IDLE   = 4'd2;
  localparam logic [3:0] ST_MLOAD  = 4'd3;
  localparam logic [3:0] ST_LOAD   = 4'd4;
  localparam logic [3:0] ST_SETTLE = 4'd5;
  localparam logic [3:0] ST_SAMPLE = 4'd6;
  localparam logic [3:0] ST_EVAL   = 4'd7;
  localparam logic [3:0] ST_APPLY  = 4'd8;
  localparam logic [3:0] ST_DONE   = 4'd9;

  localparam int CNT_W = SAMPLE_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam int TMR_W = (SET_W > CNT_W) ? SET_W : CNT_W;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SAMPLE_LAST = TMR_W'((1 << SAMPLE_LOG2) - 1);
  localparam logic [CNT_W-1:0] HIGH_THR    = CNT_W'(1 << (SAMPLE_LOG2 - 1));

  logic [3:0]       state;
  logic             fb_meta;
  logic             fb_sync;
  logic [4:0]       tap;
  logic [4:0]       manual_q;
  logic [4:0]       delay_q;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] ones_cnt;
  logic             prev_high;
  logic             high;
  logic             edge_found_q;
  logic [4:0]       edge_tap_q;

  assign high         = (ones_cnt >= HIGH_THR);
  assign busy_o       = (state == ST_LOAD) || (state == ST_SETTLE) || (state == ST_SAMPLE) ||
                        (state == ST_EVAL) || (state == ST_APPLY);
  assign done_o       = (state == ST_DONE);
  assign edge_found_o = edge_found_q;
  assign edge_tap_o   = edge_tap_q;

  // delay_o is combinational in load states so it is valid alongside the strobe
  always_comb begin
    delay_o    = delay_q;
    delay_ld_o = 1'b0;
    case (state)
      ST_INIT: begin
        delay_o    = DEFAULT_DELAY;
        delay_ld_o = 1'b1;
      end
      ST_MLOAD: begin
        delay_o    = manual_q;
        delay_ld_o = 1'b1;
      end
      ST_LOAD: begin
        delay_o    = tap;
        delay_ld_o = 1'b1;
      end
      ST_APPLY: begin
        delay_o    = edge_found_q ? edge_tap_q : DEFAULT_DELAY;
        delay_ld_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge delay_clk_i) begin
    if (rst_i) begin
      state        <= ST_RST;
      fb_meta      <= 1'b0;
      fb_sync      <= 1'b0;
      tap          <= 5'd0;
      manual_q     <= 5'd0;
      delay_q      <= DEFAULT_DELAY;
      timer        <= '0;
      ones_cnt     <= '0;
      prev_high    <= 1'b0;
      edge_found_q <= 1'b0;
      edge_tap_q   <= 5'd0;
    end else begin
      fb_meta <= fb_q_i;
      fb_sync <= fb_meta;
      delay_q <= delay_o;
      case (state)
        ST_RST:   state <= ST_INIT;
        ST_INIT:  state <= ST_IDLE;
        ST_IDLE: begin
          if (start_i) begin
            tap          <= 5'd0;
            edge_found_q <= 1'b0;
            edge_tap_q   <= 5'd0;
            state        <= ST_LOAD;
          end else if (manual_ld_i) begin
            manual_q <= manual_delay_i;
            state    <= ST_MLOAD;
          end
        end
        ST_MLOAD: state <= ST_IDLE;
        ST_LOAD: begin
          timer <= SETTLE_LAST;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer == '0) begin
            timer <= SAMPLE_LAST;
            state <= ST_SAMPLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (fb_sync) ones_cnt <= ones_cnt + 1'b1;
          if (timer == '0) state <= ST_EVAL;
          else             timer <= timer - 1'b1;
        end
        ST_EVAL: begin
          // tap 0 has no valid predecessor, so it can never be an edge
          if ((tap != 5'd0) && !prev_high && high && !edge_found_q) begin
            edge_found_q <= 1'b1;
            edge_tap_q   <= tap;
          end
          prev_high <= high;
          ones_cnt  <= '0;
          if (tap == 5'd31) begin
            state <= ST_APPLY;
          end else begin
            tap   <= tap + 5'd1;
            state <= ST_LOAD;
          end
        end
        ST_APPLY: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vcdl_delay_scan.sv
// Directed bench: reset/INIT, manual load, full default-parameter scan and
// fast-parameter sweeps driven by a tap-dependent feedback model.
module tb_vcdl_delay_scan;

  logic       clk;
  logic       rst;
  logic       start_a, manual_ld_a, fb_a;
  logic [4:0] manual_delay_a;
  logic [4:0] delay_a, edge_tap_a;
  logic       ld_a, busy_a, done_a, found_a;
  logic       start_d, manual_ld_d, fb_d;
  logic [4:0] manual_delay_d;
  logic [4:0] delay_d, edge_tap_d;
  logic       ld_d, busy_d, done_d, found_d;

  int         total = 0;
  int         bad   = 0;
  int         mode  = 2;
  logic [4:0] cur_tap = 5'd0;
  int         since = 0;

  vcdl_delay_scan #(.SETTLE_CYCLES(4), .SAMPLE_LOG2(4), .DEFAULT_DELAY(5'd7)) u_fast (
    .delay_clk_i(clk), .rst_i(rst), .start_i(start_a), .manual_ld_i(manual_ld_a),
    .manual_delay_i(manual_delay_a), .fb_q_i(fb_a), .delay_o(delay_a), .delay_ld_o(ld_a),
    .busy_o(busy_a), .done_o(done_a), .edge_found_o(found_a), .edge_tap_o(edge_tap_a)
  );

  vcdl_delay_scan u_def (
    .delay_clk_i(clk), .rst_i(rst), .start_i(start_d), .manual_ld_i(manual_ld_d),
    .manual_delay_i(manual_delay_d), .fb_q_i(fb_d), .delay_o(delay_d), .delay_ld_o(ld_d),
    .busy_o(busy_d), .done_o(done_d), .edge_found_o(found_d), .edge_tap_o(edge_tap_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // feedback as seen by the delay line: depends on loaded tap and cycles since load
  function automatic logic fb_of(input int m, input logic [4:0] t, input int s);
    case (m)
      0:       return t >= 5'd12;
      1:       return 1'b1;
      3:       return ((t >= 5'd3) && (t <= 5'd5)) || (t >= 5'd20);
      4:       return (t == 5'd9) ? ((s >= 6) && (s <= 13)) : (t > 5'd9);
      5:       return (t == 5'd9) ? ((s >= 6) && (s <= 12)) : (t >= 5'd10);
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    fb_a = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ld_a === 1'b1) begin
        cur_tap = delay_a;
        since   = 0;
      end else begin
        since = since + 1;
      end
      fb_a = fb_of(mode, cur_tap, since);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input string tag, input int m, input logic exp_found,
                          input logic [4:0] exp_tap, input logic [4:0] exp_load,
                          input int abuse_at, input logic with_manual);
    int         n;
    logic [4:0] last_ld;
    last_ld        = 5'd31;
    mode           = m;
    manual_delay_a = 5'd25;
    start_a        = 1'b1;
    manual_ld_a    = with_manual;
    step();
    start_a     = 1'b0;
    manual_ld_a = 1'b0;
    n = 1;
    chk({tag, "_busy1"}, {31'd0, busy_a}, 32'd1);
    if (with_manual) chk({tag, "_tap0_load"}, {26'd0, ld_a, delay_a}, {26'd0, 1'b1, 5'd0});
    while ((done_a !== 1'b1) && (n < 2000)) begin
      if (ld_a === 1'b1) last_ld = delay_a;
      start_a = (n == abuse_at);
      step();
      n++;
    end
    start_a = 1'b0;
    chk({tag, "_done_cycle"}, n, 32'd706);
    chk({tag, "_busy_at_done"}, {31'd0, busy_a}, 32'd0);
    chk({tag, "_found"}, {31'd0, found_a}, {31'd0, exp_found});
    chk({tag, "_edge_tap"}, {27'd0, edge_tap_a}, {27'd0, exp_tap});
    chk({tag, "_final_load"}, {27'd0, last_ld}, {27'd0, exp_load});
    step();
    chk({tag, "_done_pulse"}, {31'd0, done_a}, 32'd0);
  endtask

  initial begin
    int         n;
    logic [4:0] last_ld;
    logic       seen;
    rst = 1'b1;
    start_a = 1'b0; manual_ld_a = 1'b0; manual_delay_a = 5'd0;
    start_d = 1'b0; manual_ld_d = 1'b0; manual_delay_d = 5'd0; fb_d = 1'b0;
    repeat (3) step();
    chk("rst_delay", {27'd0, delay_d}, 32'd0);
    chk("rst_ld", {31'd0, ld_d}, 32'd0);
    chk("rst_busy", {31'd0, busy_d}, 32'd0);
    chk("rst_done", {31'd0, done_d}, 32'd0);
    chk("rst_found", {31'd0, found_d}, 32'd0);
    chk("rst_edge_tap", {27'd0, edge_tap_d}, 32'd0);
    chk("rst_delay_fast", {26'd0, ld_a, delay_a}, {26'd0, 1'b0, 5'd7});
    rst = 1'b0;
    step();
    chk("init_ld", {26'd0, ld_d, delay_d}, {26'd0, 1'b1, 5'd0});
    chk("init_ld_fast", {26'd0, ld_a, delay_a}, {26'd0, 1'b1, 5'd7});
    step();
    chk("init_single", {31'd0, ld_d}, 32'd0);
    repeat (2) step();

    manual_delay_d = 5'd19;
    manual_ld_d = 1'b1;
    step();
    manual_ld_d = 1'b0;
    chk("manual_load", {26'd0, ld_d, delay_d}, {26'd0, 1'b1, 5'd19});
    chk("manual_busy", {31'd0, busy_d}, 32'd0);
    step();
    chk("manual_hold", {26'd0, ld_d, delay_d}, {26'd0, 1'b0, 5'd19});

    start_d = 1'b1;
    step();
    start_d = 1'b0;
    n = 1;
    last_ld = 5'd31;
    while ((done_d !== 1'b1) && (n < 9000)) begin
      if (ld_d === 1'b1) last_ld = delay_d;
      step();
      n++;
    end
    chk("def_done_cycle", n, 32'd8770);
    chk("def_found", {31'd0, found_d}, 32'd0);
    chk("def_final_load", {27'd0, last_ld}, 32'd0);

    run_scan("edge12", 0, 1'b1, 5'd12, 5'd12, 0, 1'b1);
    run_scan("all_high", 1, 1'b0, 5'd0, 5'd7, 0, 1'b0);
    run_scan("all_low", 2, 1'b0, 5'd0, 5'd7, 0, 1'b0);
    run_scan("first_only", 3, 1'b1, 5'd3, 5'd3, 0, 1'b0);
    run_scan("thr_8of16", 4, 1'b1, 5'd9, 5'd9, 0, 1'b0);
    run_scan("thr_7of16", 5, 1'b1, 5'd10, 5'd10, 0, 1'b0);
    run_scan("restart_ign", 0, 1'b1, 5'd12, 5'd12, 400, 1'b0);

    mode = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n = 1;
    while (n < 331) begin
      step();
      n++;
    end
    chk("tap15_load", {26'd0, ld_a, delay_a}, {26'd0, 1'b1, 5'd15});
    chk("pre_rst_found", {31'd0, found_a}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_found", {31'd0, found_a}, 32'd0);
    chk("midrst_busy", {31'd0, busy_a}, 32'd0);
    chk("midrst_ld", {26'd0, ld_a, delay_a}, {26'd0, 1'b0, 5'd7});
    step();
    chk("midrst_init", {26'd0, ld_a, delay_a}, {26'd0, 1'b1, 5'd7});
    seen = 1'b0;
    repeat (800) begin
      step();
      if (done_a === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", {31'd0, seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vcdl_delay_scan.md
# vcdl_delay_scan

Calibration controller that drives the 5-bit tap delay of the VCDL delay stage and reads back that stage's feedback sample to locate the VCDL edge. It sits directly upstream of the VCDL delay wrapper: its `delay_o` / `delay_ld_o` outputs feed the wrapper's `delay_i` / `delay_ld_i`, and the wrapper's `vcdl_fb_q_o` returns as `fb_q_i`. On command it sweeps taps 0–31, majority-votes the feedback at each tap, records the first low→high transition, and loads that tap (or a default) into the delay line.

## Interface
- `SETTLE_CYCLES`, 16, cycles waited after each tap load before sampling; must be ≥ 2.
- `SAMPLE_LOG2`, 8, log2 of the number of feedback samples per tap; range 1–12.
- `DEFAULT_DELAY`, 5'd0, tap loaded after reset and when no edge is found.
- `delay_clk_i  in  1`  block clock; this is the same clock as the wrapper's `delay_clk_i`.
- `rst_i  in  1`  reset, synchronous, active-high.
- `start_i  in  1`  single-cycle scan request.
- `manual_ld_i  in  1`  single-cycle request to load `manual_delay_i`.
- `manual_delay_i  in  5`  manual tap value.
- `fb_q_i  in  1`  feedback sample from the wrapper; asynchronous to `delay_clk_i`.
- `delay_o  out  5`  tap value to the wrapper.
- `delay_ld_o  out  1`  one-cycle load strobe to the wrapper.
- `busy_o  out  1`  high while a scan is in progress.
- `done_o  out  1`  one-cycle pulse at the end of a scan.
- `edge_found_o  out  1`  the last scan found a low→high edge.
- `edge_tap_o  out  5`  tap of the last found edge.

## Operation
- `fb_q_i` passes through a 2-FF synchronizer; all sampling uses the synchronized value.
- States:
  - INIT: first cycle after reset. `delay_o` = `DEFAULT_DELAY`, `delay_ld_o` = 1. Always → IDLE.
  - IDLE:
    - `start_i` → LOAD with tap = 0.
    - Otherwise `manual_ld_i` → MLOAD. When both are asserted, `start_i` wins and the manual request is dropped.
  - MLOAD: `delay_o` = `manual_delay_i` (captured in IDLE), `delay_ld_o` = 1 → IDLE.
  - LOAD: `delay_o` = tap, `delay_ld_o` = 1 → SETTLE.
  - SETTLE: counts `SETTLE_CYCLES` cycles → SAMPLE.
  - SAMPLE: for 2^`SAMPLE_LOG2` cycles, the ones-counter (width `SAMPLE_LOG2`+1) increments on each synchronized sample equal to 1. No saturation is needed.
  - EVAL:
    - `high` = (count ≥ 2^(`SAMPLE_LOG2`−1)).
    - If tap ≠ 0, `!prev_high`, `high`, and no edge has been found yet this scan: set `edge_found_o` = 1 and `edge_tap_o` = tap.
    - `prev_high` ← `high`; clear the counter.
    - If tap = 31 → APPLY; otherwise tap+1 → LOAD.
  - APPLY: `delay_o` = `edge_tap_o` if an edge was found, else `DEFAULT_DELAY`; `delay_ld_o` = 1 → DONE.
  - DONE: `done_o` = 1 → IDLE.
- `start_i` clears `edge_found_o` and `edge_tap_o` to 0 on the LOAD entry for tap 0.
- Tap 0 can never be reported as an edge. Only the first edge of a scan counts; later edges are ignored.
- A sweep that is high at every tap, or low at every tap, reports `edge_found_o` = 0.
- `start_i` and `manual_ld_i` are ignored outside IDLE; they are not queued.
- `delay_o` holds its last loaded value between loads. `delay_ld_o` is high only in INIT, MLOAD, LOAD and APPLY.

## Timing
- Reset values: `delay_o` = `DEFAULT_DELAY`, `delay_ld_o` = 0, `busy_o` = 0, `done_o` = 0, `edge_found_o` = 0, `edge_tap_o` = 0. Synchronizer, counters and `prev_high` are cleared.
- INIT strobe: in the first cycle after `rst_i` falls, `delay_ld_o` = 1.
- Manual load: `manual_ld_i` high in cycle N (IDLE) → `delay_o` = `manual_delay_i` and `delay_ld_o` = 1 in cycle N+1.
- Scan timing, with `start_i` sampled in cycle 0 and T = `SETTLE_CYCLES` + 2^`SAMPLE_LOG2` + 2:
  - `busy_o` = 1 from cycle 1.
  - Tap k is loaded in cycle 1 + k·T.
  - APPLY is in cycle 32·T+1.
  - `done_o` = 1 in cycle 32·T+2, with `busy_o` = 0 in that same cycle.
  - With defaults, `done_o` is in cycle 8770.
- `delay_o` is always valid in the same cycle `delay_ld_o` is high.
- `rst_i` mid-scan: the next cycle has reset values, then INIT. `done_o` is not pulsed, and edge results are cleared.

## Test plan
- Reset: pulse `rst_i` → all outputs at reset values, then exactly one `delay_ld_o` with `delay_o` = `DEFAULT_DELAY`.
- Manual load: in IDLE, `manual_delay_i` = 5'd19 with `manual_ld_i` → next cycle `delay_o` = 19, `delay_ld_o` = 1; `busy_o` stays 0.
- Edge sweep: `SETTLE_CYCLES` = 4, `SAMPLE_LOG2` = 4; fb model returns 0 for taps < 12 and 1 for taps ≥ 12 → `edge_found_o` = 1, `edge_tap_o` = 12, final load of 12, and `done_o` in cycle 32·22+2 = 706.
- No edge: fb held at 1, then at 0, each with `DEFAULT_DELAY` = 7 → `edge_found_o` = 0 and final load of 7. Also: fb is 1 for taps 3–5 and 20–31 → `edge_tap_o` = 3.
- Threshold: at tap 9, fb is high for exactly 8 of 16 samples (taps < 9 all low) → edge at 9. With 7 of 16 high at tap 9 and tap 10 fully high → edge at 10.
- Abuse: `start_i` pulsed mid-scan → completion timing is unchanged. `rst_i` at tap 15 → no `done_o`, INIT load follows, and `edge_found_o` = 0.
